// File: rtl/line_fill_engine_pkg.sv
// rtl/line_fill_engine_pkg.sv - shared constants and FSM state type for the line fill engine
package line_fill_engine_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int WORDS_PER_LINE = 16;
  localparam int BYTES_PER_WORD = 4;

  localparam int TAG_W      = 18;
  localparam int SET_W      = 8;
  localparam int WORD_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/line_fill_engine_word_packer.sv
// rtl/line_fill_engine_word_packer.sv - packs a byte stream big-endian into 32-bit words
module word_packer
  import line_fill_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_data
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [31:0]      word_q, word_d;
  logic             word_valid_q, word_valid_d;

  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (byte_valid) begin
      if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
        // earliest byte already sits in shift_q[23:16], so it lands in [31:24]
        word_d       = {shift_q, byte_in};
        word_valid_d = 1'b1;
        cnt_d        = '0;
      end else begin
        shift_d = {shift_q[15:0], byte_in};
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_q;

endmodule

// File: rtl/line_fill_engine.sv
// rtl/line_fill_engine.sv - fetches a 64-byte cache line bytewise and presents it as 16 words
module line_fill_engine
  import line_fill_engine_pkg::*;
#(
  parameter int WORDS_PER_LINE = 16,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  mem_rd,
  output logic [31:0]           mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  fill_valid,
  output logic [WORD_IDX_W-1:0] fill_index,
  output logic [31:0]           fill_data,
  output logic [SET_W-1:0]      fill_set,
  output logic [TAG_W-1:0]      fill_tag,
  output logic                  fill_done
);

  localparam int LINE_B = WORDS_PER_LINE * BYTES_PER_WORD;
  localparam int OFF_W  = $clog2(LINE_B);

  fill_state_e           state_q, state_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           base_q, base_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [SET_W-1:0]      set_q, set_d;
  logic [WORD_IDX_W-1:0] widx_q, widx_d;
  logic                  rd_dly_q, rd_dly_d;

  logic                  word_valid;
  logic [31:0]           word_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    tag_d     = tag_q;
    set_d     = set_q;
    widx_d    = widx_q;
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    fill_done = 1'b0;

    if (word_valid) begin
      widx_d = widx_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          base_d  = req_addr & ~32'(LINE_B - 1);
          tag_d   = req_addr[31:32-TAG_W];
          set_d   = req_addr[OFF_W +: SET_W];
          cnt_d   = '0;
          widx_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + 32'(cnt_q);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == OFF_W'(LINE_B - 1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // last word is registered out of the packer in this same cycle
        fill_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // memory answers one cycle after the strobe, so capture follows it by one
    rd_dly_d = mem_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      tag_q    <= '0;
      set_q    <= '0;
      widx_q   <= '0;
      rd_dly_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      tag_q    <= tag_d;
      set_q    <= set_d;
      widx_q   <= widx_d;
      rd_dly_q <= rd_dly_d;
    end
  end

  word_packer u_word_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (rd_dly_q),
    .byte_in    (mem_rdata),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  assign fill_valid = word_valid;
  assign fill_index = widx_q;
  assign fill_data  = word_data;
  assign fill_set   = set_q;
  assign fill_tag   = tag_q;

endmodule

// File: tb/tb_line_fill_engine.sv
// tb/tb_line_fill_engine.sv - directed self-checking bench for line_fill_engine
module tb_line_fill_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        fill_valid;
  logic [3:0]  fill_index;
  logic [31:0] fill_data;
  logic [7:0]  fill_set;
  logic [17:0] fill_tag;
  logic        fill_done;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  endian_mode = 1'b0;

  line_fill_engine #(.WORDS_PER_LINE(16), .BYTES_PER_WORD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_index (fill_index),
    .fill_data  (fill_data),
    .fill_set   (fill_set),
    .fill_tag   (fill_tag),
    .fill_done  (fill_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    if (endian_mode && a[5:2] == 4'd0) begin
      case (a[1:0])
        2'd0:    return 8'h11;
        2'd1:    return 8'h22;
        2'd2:    return 8'h33;
        default: return 8'h44;
      endcase
    end
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= byte_at(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " req_ready"},  32'(req_ready),  32'd1);
    chk({tag, " mem_rd"},     32'(mem_rd),     32'd0);
    chk({tag, " mem_addr"},   mem_addr,        32'd0);
    chk({tag, " fill_valid"}, 32'(fill_valid), 32'd0);
    chk({tag, " fill_done"},  32'(fill_done),  32'd0);
    chk({tag, " fill_index"}, 32'(fill_index), 32'd0);
    chk({tag, " fill_data"},  fill_data,       32'd0);
    chk({tag, " fill_set"},   32'(fill_set),   32'd0);
    chk({tag, " fill_tag"},   32'(fill_tag),   32'd0);
  endtask

  // Accept at edge 0, then check every cycle 1..67 against the cycle map.
  task automatic do_fill(input logic [31:0] addr, input logic [31:0] exp_base,
                         input logic [17:0] exp_tag, input logic [7:0] exp_set,
                         input bit keep, input logic [31:0] addr2,
                         output logic [31:0] w0, output int rd_count);
    logic [31:0] exp_word;
    int          wi;
    rd_count  = 0;
    w0        = 32'hx;
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    if (keep) req_addr = addr2;
    else      req_valid = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      chk($sformatf("c%0d req_ready", c), 32'(req_ready), (c == 67) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d mem_rd", c), 32'(mem_rd), (c >= 1 && c <= 64) ? 32'd1 : 32'd0);
      if (mem_rd) rd_count++;
      if (c >= 1 && c <= 64)
        chk($sformatf("c%0d mem_addr", c), mem_addr, exp_base + 32'(c - 1));
      chk($sformatf("c%0d fill_tag", c), 32'(fill_tag), 32'(exp_tag));
      chk($sformatf("c%0d fill_set", c), 32'(fill_set), 32'(exp_set));
      chk($sformatf("c%0d fill_done", c), 32'(fill_done), (c == 66) ? 32'd1 : 32'd0);
      if (c >= 6 && c <= 66 && ((c - 6) % 4) == 0) begin
        wi = (c - 6) / 4;
        exp_word = {byte_at(exp_base + 32'(4*wi)),     byte_at(exp_base + 32'(4*wi + 1)),
                    byte_at(exp_base + 32'(4*wi + 2)), byte_at(exp_base + 32'(4*wi + 3))};
        chk($sformatf("c%0d fill_valid", c), 32'(fill_valid), 32'd1);
        chk($sformatf("c%0d fill_index", c), 32'(fill_index), 32'(wi));
        chk($sformatf("c%0d fill_data", c), fill_data, exp_word);
        if (wi == 0) w0 = fill_data;
      end else begin
        chk($sformatf("c%0d fill_valid", c), 32'(fill_valid), 32'd0);
      end
      if (c < 67) step();
    end
  endtask

  logic [31:0] w0;
  int          rdc;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h1234_5678;
    step();
    step();
    check_reset_outputs("reset");
    rst       = 1'b0;
    req_valid = 1'b0;
    step();
    chk("idle req_ready", 32'(req_ready), 32'd1);

    // Scenario 1: basic fill, low address bits ignored
    do_fill(32'h0001_2345, 32'h0001_2340, 18'h00004, 8'h8D, 1'b0, 32'h0, w0, rdc);
    chk("s1 tag", 32'(fill_tag), 32'h4);
    chk("s1 set", 32'(fill_set), 32'h8D);
    chk("s1 rd count", 32'(rdc), 32'd64);

    // Scenario 2: big-endian packing
    endian_mode = 1'b1;
    do_fill(32'h0000_0080, 32'h0000_0080, 18'h0, 8'h02, 1'b0, 32'h0, w0, rdc);
    chk("s2 word0", w0, 32'h1122_3344);
    endian_mode = 1'b0;

    // Scenario 3: req_valid held with a new address during the fill
    do_fill(32'h0000_1000, 32'h0000_1000, 18'h0, 8'h40, 1'b1, 32'h0ABC_D040, w0, rdc);
    chk("s3 ready before 2nd", 32'(req_ready), 32'd1);
    do_fill(32'h0ABC_D040, 32'h0ABC_D040, 18'h02AF3, 8'h41, 1'b0, 32'h0, w0, rdc);

    // Scenario 4: reset in the middle of a fill
    req_valid = 1'b1;
    req_addr  = 32'h0000_2000;
    step();
    req_valid = 1'b0;
    for (int c = 1; c < 30; c++) step();
    chk("s4 mid mem_rd", 32'(mem_rd), 32'd1);
    chk("s4 mid mem_addr", mem_addr, 32'h0000_2000 + 32'd29);
    rst = 1'b1;
    step();
    check_reset_outputs("s4 reset");
    rst = 1'b0;
    step();
    chk("s4 ready after", 32'(req_ready), 32'd1);
    begin
      int fv = 0;
      int fd = 0;
      for (int c = 0; c < 50; c++) begin
        if (fill_valid) fv++;
        if (fill_done)  fd++;
        step();
      end
      chk("s4 no fill_valid", 32'(fv), 32'd0);
      chk("s4 no fill_done", 32'(fd), 32'd0);
    end

    // Scenario 5: top-of-memory line, no carry out
    do_fill(32'hFFFF_FFFF, 32'hFFFF_FFC0, 18'h3FFFF, 8'hFF, 1'b0, 32'h0, w0, rdc);
    chk("s5 tag", 32'(fill_tag), 32'h3FFFF);
    chk("s5 set", 32'(fill_set), 32'hFF);
    chk("s5 rd count", 32'(rdc), 32'd64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_fill_engine.md
LINE_FILL_ENGINE -- requirements
Module: line_fill_engine

Interface
REQ-001 Parameter WORDS_PER_LINE, 16, words per cache line (sets the 64-byte line size).
REQ-002 Parameter BYTES_PER_WORD, 4, bytes packed per 32-bit word.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  miss request from the cache lookup stage.
REQ-006 req_addr  input  32  byte address of the missing access.
REQ-007 req_ready  output  1  engine idle; a request is accepted when req_valid & req_ready.
REQ-008 mem_rd  output  1  byte read strobe to main memory.
REQ-009 mem_addr  output  32  byte address for the mem_rd strobe.
REQ-010 mem_rdata  input  8  byte returned exactly one cycle after mem_rd.
REQ-011 fill_valid  output  1  one-cycle strobe: fill_data is valid for fill_index.
REQ-012 fill_index  output  4  word slot within the line, 0..15.
REQ-013 fill_data  output  32  assembled word.
REQ-014 fill_set  output  8  line set index, req_addr[13:6] latched at accept.
REQ-015 fill_tag  output  18  line tag, req_addr[31:14] latched at accept.
REQ-016 fill_done  output  1  one-cycle strobe: the line is complete, so the tag may be written.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-018 IDLE: req_ready=1; on accept, latch base = req_addr & 0xFFFF_FFC0, plus tag and set, then go to ISSUE.
REQ-019 ISSUE: issue mem_rd=1 for 64 consecutive cycles, with mem_addr = base+0 .. base+63 in ascending order, then go to DRAIN.
REQ-020 DRAIN: mem_rd=0; capture the final byte, then go to DONE.
REQ-021 DONE: hold one cycle, then return to IDLE; req_ready is 0 in every state except IDLE.
REQ-022 Byte packing is big-endian: the byte at the lowest address within a word goes to fill_data[31:24] and the highest to [7:0].
REQ-023 A word at line offset 4i..4i+3 is presented with fill_index = i.
REQ-024 Timing, with the accept edge at cycle 0: mem_rd is high in cycles 1..64, and bytes are captured in cycles 2..65.
REQ-025 Each word is registered and presented the cycle after its 4th byte is captured, so word i appears at cycle 4i+6 (word 0 at cycle 6, word 15 at cycle 66).
REQ-026 fill_done is asserted in the same cycle as the fill_valid for index 15 (cycle 66).
REQ-027 req_ready returns to 1 at cycle 67, giving a minimum request-to-request spacing of 67 cycles.
REQ-028 req_valid is ignored while req_ready=0; no queuing, and the latched address is not disturbed.
REQ-029 req_addr bits [5:0] do not affect the fill; fill order always starts at offset 0.
REQ-030 Address arithmetic is 32-bit modulo, so base 0xFFFF_FFC0 reads 0xFFFF_FFC0..0xFFFF_FFFF with no carry into other state.
REQ-031 fill_valid, fill_done and mem_rd are 0 whenever not explicitly asserted above.

Reset
REQ-032 While rst=1 at a clock edge the engine enters IDLE, and all outputs take these values: req_ready=1; mem_rd=0; mem_addr=0; fill_valid=0; fill_done=0; fill_index=0; fill_data=0; fill_set=0; fill_tag=0.
REQ-033 A reset during ISSUE, DRAIN or DONE aborts the fill: no further fill_valid or fill_done is produced, and any partial word is discarded.
REQ-034 A request is not accepted in a cycle where rst=1.

Structure
REQ-035 The shared package holds:
- LINE_BYTES=64, WORDS_PER_LINE=16 and BYTES_PER_WORD=4;
- field widths TAG_W=18, SET_W=8 and WORD_IDX_W=4;
- the FSM state enum.
REQ-036 One sub-module, word_packer, holds the 4-byte big-endian shift register and byte counter, and emits the word plus a word-complete pulse; the FSM and address counter stay in the top module.

Verification
REQ-037 A byte-memory model returns mem_rdata = mem_addr[7:0] ^ 0xA5 one cycle after mem_rd; the bench checks every word against this model.
REQ-038 Scenario 1: request with req_addr=0x0001_2345.
- Expected: base 0x0001_2340, fill_tag=0x0004, fill_set=0x8D.
- Expected: 16 fill_valid pulses at cycles 6,10,...,66 with fill_index 0..15.
- Expected: fill_done at cycle 66 only; req_ready high at cycle 67.
REQ-039 Scenario 2: endian check with memory bytes 0x11,0x22,0x33,0x44 at base+0..3 -> word 0 = 0x11223344.
REQ-040 Scenario 3: req_valid held high throughout a fill, with a different address -> the second request is accepted only at cycle 67, and the first fill's tag and set are unchanged.
REQ-041 Scenario 4: rst asserted at cycle 30 -> no fill_done, no fill_valid after reset, outputs match REQ-032, and req_ready=1 the next cycle.
REQ-042 Scenario 5: req_addr=0xFFFF_FFFF -> mem_addr runs 0xFFFF_FFC0..0xFFFF_FFFF, fill_tag=0x3FFFF, fill_set=0xFF, and exactly 64 mem_rd strobes are seen.
